// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, start/data/stop sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned D_WIDTH      = 11,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned BW   = $clog2(D_WIDTH + 1);
    localparam int unsigned PW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [PW-1:0] PhLast  = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PhHalf  = PW'(HALF);
    localparam logic [BW-1:0] BitLast = BW'(D_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [PW-1:0]        phase_q, phase_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [D_WIDTH-1:0]   shreg_q, shreg_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 deliver;
    logic                 rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    bit_d = '0;
                    // With HALF == 0 the detection cycle doubles as the start check.
                    if (HALF == 0) begin
                        state_d = StData;
                        phase_d = '0;
                    end else begin
                        state_d = StStart;
                        phase_d = PW'(1);
                    end
                end
            end
            StStart: begin
                if (phase_q == PhHalf) begin
                    phase_d = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            StData: begin
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    shreg_d = (shreg_q >> 1) | (D_WIDTH'(rx_s) << (D_WIDTH - 1));
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            StStop: begin
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A delivery takes precedence over the plain handshake clear.
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StIdle;
            phase_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: builds per-cycle line/ready/reset tables, derives
// expected outputs from the frame timeline, and compares every cycle.
module tb_uart_rx;

    localparam int D    = 11;
    localparam int MAXN = 16000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, rx_a = 1'b1, rdy_a = 1'b0;
    logic          rst_b = 1'b1, rx_b = 1'b1, rdy_b = 1'b0;
    logic [D-1:0]  data_a, data_b;
    logic          valid_a, busy_a, fe_a, ov_a;
    logic          valid_b, busy_b, fe_b, ov_b;

    uart_rx #(.D_WIDTH(D), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .rst(rst_a), .rx(rx_a), .rx_ready(rdy_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_busy(busy_a), .frame_err(fe_a), .overrun(ov_a)
    );

    uart_rx #(.D_WIDTH(D), .CLKS_PER_BIT(16)) dut_b (
        .clk(clk), .rst(rst_b), .rx(rx_b), .rx_ready(rdy_b), .rx_data(data_b),
        .rx_valid(valid_b), .rx_busy(busy_b), .frame_err(fe_b), .overrun(ov_b)
    );

    // Per-edge tables: index t is what the DUT sees at (and what it shows after) edge t.
    logic         line_v [MAXN];
    logic         rst_v  [MAXN];
    logic         rdy_v  [MAXN];
    logic         busy_v [MAXN];
    int           ev_v   [MAXN];  // 0 none, 1 good frame, 2 framing error
    logic [D-1:0] evd_v  [MAXN];

    int len;
    int rdy_mode;  // 0 ready low, 1 ready high, 2 random
    int cpb;
    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cpb=%0d cycle %0d: got %0h expected %0h", tag, cpb, cyc, got, exp);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < MAXN; i++) begin
            line_v[i] = 1'b1;
            rst_v[i]  = 1'b0;
            rdy_v[i]  = 1'b0;
            busy_v[i] = 1'b0;
            ev_v[i]   = 0;
            evd_v[i]  = '0;
        end
        len = 0;
    endtask

    task automatic put(input logic b, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (len < MAXN) begin
                line_v[len] = b;
                rdy_v[len]  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
                len++;
            end
        end
    endtask

    task automatic add_frame(input logic [D-1:0] d, input int nstop);
        put(1'b0, cpb);
        for (int i = 0; i < D; i++) put(d[i], cpb);
        put(1'b1, nstop * cpb);
    endtask

    task automatic add_bad(input logic [D-1:0] d, input int extra_low);
        put(1'b0, cpb);
        for (int i = 0; i < D; i++) put(d[i], cpb);
        put(1'b0, cpb + extra_low);
    endtask

    // Synchronised line value the receiver acts on at edge t.
    function automatic logic rxs(input int t);
        if (t < 2 || t - 2 >= MAXN) return 1'b1;
        if (rst_v[t-1] || rst_v[t-2]) return 1'b1;
        return line_v[t-2];
    endfunction

    // Walk the line using the sample timeline and record frame events and busy spans.
    task automatic build_model();
        int t, c0, fend, bend, s, kind, half;
        logic [D-1:0] word;
        half = (cpb - 1) / 2;
        t = 0;
        while (t < len) begin
            if (rst_v[t] || rxs(t)) begin
                t++;
                continue;
            end
            c0   = t;
            kind = 0;
            word = '0;
            if (half > 0 && rxs(c0 + half)) begin
                fend = c0 + half;
            end else begin
                for (int i = 0; i < D; i++) word[i] = rxs(c0 + half + (i + 1) * cpb);
                s    = c0 + half + (D + 1) * cpb;
                fend = s;
                kind = rxs(s) ? 1 : 2;
            end
            bend = fend;
            for (int r = c0 + 1; r <= fend && r < MAXN; r++) begin
                if (rst_v[r]) begin
                    kind = 0;
                    fend = r;
                    bend = r;
                    break;
                end
            end
            if (kind == 2) begin
                bend = fend + 1;
                while (bend < MAXN - 1 && !rxs(bend) && !rst_v[bend]) bend++;
            end
            if (kind != 0 && fend < MAXN) begin
                ev_v[fend]  = kind;
                evd_v[fend] = word;
            end
            for (int e = c0; e < bend && e < MAXN; e++) busy_v[e] = 1'b1;
            t = bend + 1;
        end
    endtask

    task automatic run(input int sel);
        logic         valid_m, fe_m, ov_m;
        logic [D-1:0] data_m;
        valid_m = 1'b0;
        data_m  = '0;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (sel == 0) begin
                rx_a = line_v[t]; rdy_a = rdy_v[t]; rst_a = rst_v[t];
            end else begin
                rx_b = line_v[t]; rdy_b = rdy_v[t]; rst_b = rst_v[t];
            end
            @(posedge clk);
            #1;
            cyc  = t;
            fe_m = 1'b0;
            ov_m = 1'b0;
            if (rst_v[t]) begin
                valid_m = 1'b0;
                data_m  = '0;
            end else if (ev_v[t] == 1) begin
                if (!valid_m || rdy_v[t]) begin
                    valid_m = 1'b1;
                    data_m  = evd_v[t];
                end else begin
                    ov_m = 1'b1;
                end
            end else begin
                if (ev_v[t] == 2) fe_m = 1'b1;
                if (valid_m && rdy_v[t]) valid_m = 1'b0;
            end
            check_eq("rx_valid",  32'(sel ? valid_b : valid_a), 32'(valid_m));
            check_eq("rx_data",   32'(sel ? data_b  : data_a),  32'(data_m));
            check_eq("rx_busy",   32'(sel ? busy_b  : busy_a),  32'(busy_v[t]));
            check_eq("frame_err", 32'(sel ? fe_b    : fe_a),    32'(fe_m));
            check_eq("overrun",   32'(sel ? ov_b    : ov_a),    32'(ov_m));
        end
    endtask

    task automatic add_random(input int iters);
        int st, k;
        logic [D-1:0] d;
        for (int it = 0; it < iters; it++) begin
            rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
            k  = $urandom_range(0, 11);
            d  = D'($urandom);
            st = len;
            if (k == 0)      add_bad(d, $urandom_range(0, 3));
            else if (k == 1) put(1'b0, $urandom_range(1, cpb));
            else             add_frame(d, $urandom_range(1, 2));
            if ($urandom_range(0, 24) == 0 && len > st) rst_v[st + $urandom_range(0, len - st - 1)] = 1'b1;
            put(1'b1, $urandom_range(0, 2 * cpb));
        end
    endtask

    task automatic add_reset_start();
        rdy_mode = 1;
        put(1'b1, 3);
        rst_v[0] = 1'b1; rst_v[1] = 1'b1; rst_v[2] = 1'b1;
        put(1'b1, 4);
    endtask

    initial begin
        int st;

        // Default parameters: directed cases then random traffic.
        cpb = 1;
        clear_tables();
        add_reset_start();
        add_frame(11'h5A5, 2);
        put(1'b1, 3);
        add_bad(11'h123, 4);
        put(1'b1, 2);
        add_frame(11'h321, 1);
        put(1'b1, 3);
        rdy_mode = 0;
        add_frame(11'h0AA, 1);
        add_frame(11'h155, 1);
        put(1'b1, 2);
        rdy_mode = 1;
        put(1'b1, 1);
        rdy_mode = 0;
        put(1'b1, 3);
        rdy_mode = 1;
        st = len;
        add_frame(11'h4E7, 1);
        rst_v[st + 2 + 6 * cpb] = 1'b1;
        put(1'b1, 4);
        add_frame(11'h2C3, 1);
        put(1'b1, 4);
        add_random(150);
        rdy_mode = 2;
        put(1'b1, 40);
        build_model();
        run(0);
        rst_a = 1'b1;

        // CLKS_PER_BIT = 16: back-to-back, glitch, then random traffic.
        cpb = 16;
        clear_tables();
        add_reset_start();
        add_frame(11'h000, 1);
        add_frame(11'h7FF, 1);
        put(1'b1, 20);
        put(1'b0, 5);
        put(1'b1, 30);
        add_bad(11'h0F0, 10);
        put(1'b1, 20);
        add_random(20);
        rdy_mode = 2;
        put(1'b1, 40 * cpb);
        build_model();
        run(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmitter and reconstructs its frames. It consumes the `tx` line: idle high, one start bit (0), `D_WIDTH` data bits LSB first, then stop bit(s) at 1. It delivers each frame as a parallel word through a one-entry valid/ready holding register and flags framing errors and overruns. Bit period is a parameter; the default of 1 clock per bit pairs directly with the transmitter.

## Interface
- `D_WIDTH`, 11: data bits per frame.
- `CLKS_PER_BIT`, 1: clocks per bit period, must be ≥1. `HALF = (CLKS_PER_BIT-1)/2` (integer division).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `rx_data`  out  `D_WIDTH`  received word, bit 0 = first data bit on the line.
- `rx_valid`  out  1  holding register full.
- `rx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: frame completed while holding register full and not being drained.

## Operation
- Input synchroniser: two flops, both reset to 1; the FSM sees only `rx_s`, the second flop.
- Sample timeline: cycle 0 is the first cycle in IDLE where `rx_s == 0`.
  - Start bit is checked at cycle `HALF`.
  - Data bit i (0..D_WIDTH-1) is sampled at cycle `HALF + (i+1)*CLKS_PER_BIT`.
  - Stop bit is sampled at cycle `HALF + (D_WIDTH+1)*CLKS_PER_BIT`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START when `rx_s == 0`. If `HALF == 0`, the detection cycle is the start check and the FSM goes directly to DATA.
  - START: if the start check reads `rx_s == 1`, treat it as a glitch and return to IDLE with no flags. Otherwise go to DATA.
  - DATA: shift each sample into a `D_WIDTH` shift register LSB first. After bit `D_WIDTH-1`, go to STOP.
  - STOP, stop sample 1: deliver the word and go to IDLE. The next start can be detected on the following cycle.
  - STOP, stop sample 0: pulse `frame_err`, discard the word, and go to BREAK.
  - BREAK -> IDLE on the first cycle with `rx_s == 1`.
- Bit counter width is `clog2(D_WIDTH+1)`. The phase counter wraps at `CLKS_PER_BIT-1`. Neither counter may overflow for any legal parameter value.
- Delivery on a good stop sample:
  - `!rx_valid`, or `rx_valid && rx_ready`: load `rx_data`; `rx_valid` is 1 afterwards.
  - `rx_valid && !rx_ready`: keep the old word, drop the new one, pulse `overrun`.
- Handshake: with no delivery in the same cycle, `rx_valid && rx_ready` clears `rx_valid`. `rx_data` holds its value while `rx_valid` is high.
- `frame_err` and `overrun` are never asserted in the same cycle.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `rx_busy` = 0, `frame_err` = 0, `overrun` = 0, synchroniser = 1, state = IDLE.
- Reset mid-frame aborts the frame: no delivery and no flags. `rst` has priority over every other event.
- Latency: if `rx` first reads 0 at edge k (captured into synchroniser flop 1), then:
  - cycle 0 is edge k+2;
  - the stop sample is at edge k+2+`HALF`+(`D_WIDTH`+1)·`CLKS_PER_BIT`;
  - `rx_valid`, `frame_err` or `overrun` are visible immediately after that edge.
  - Default parameters: edge k+14.
- `rx_busy` rises after the edge at which cycle 0 is sampled. It falls after the stop-sample edge, or after BREAK exits.
- Back-to-back frames with a single stop bit are received with no lost bits.

## Test plan
- Default parameters, transmitter-shaped frame for 0x5A5 (line: 1, 0, bits LSB first, 1, 1) -> `rx_data` = 0x5A5, `rx_valid` rises at edge k+14, `frame_err` = 0.
- `CLKS_PER_BIT` = 16, frames 0x000 then 0x7FF back-to-back with one stop bit each, `rx_ready` held 1 -> two deliveries, exactly 13·16 cycles apart.
- `CLKS_PER_BIT` = 16, line low for 5 cycles then high -> no `rx_valid`, no flags, `rx_busy` returns to 0 at cycle `HALF`.
- Default parameters, 0x123 with stop bit forced 0, line held 0 for 4 more cycles -> one-cycle `frame_err`, `rx_valid` stays 0, FSM stays in BREAK until the line goes high, then the next frame 0x321 is received correctly.
- `rx_ready` = 0, two frames 0x0AA and 0x155 -> `rx_data` = 0x0AA held, `overrun` pulses once at the second stop sample. Then `rx_ready` = 1 for 1 cycle -> `rx_valid` = 0.
- Assert `rst` at data bit 5 of a frame -> all outputs return to reset values the next cycle. A following clean frame 0x2C3 is received.
